// File: rtl/seq_cmp32_ctrl.sv
// Sequential magnitude comparator: one 4-bit nibble comparator is walked
// from the most significant nibble down, stopping at the first difference.
// Results are held in DONE until the consumer takes them.
module seq_cmp32_ctrl #(
    parameter  int WIDTH = 32,
    localparam int N     = WIDTH / 4,
    localparam int CW    = $clog2(N) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             eq,
    output logic             gt,
    output logic             lt,
    output logic [CW-1:0]    nib_cnt,
    output logic             busy
);

    // Nibble index needs at least one bit even when there is a single nibble
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CMP,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             eq_q, eq_d;
    logic             gt_q, gt_d;
    logic             lt_q, lt_d;

    logic [3:0]       nib_a;
    logic [3:0]       nib_b;
    logic             nib_eq;
    logic             nib_gt;

    // The single shared nibble comparator, fed by the currently indexed nibble
    always_comb begin
        nib_a  = 4'(a_q >> {idx_q, 2'b00});
        nib_b  = 4'(b_q >> {idx_q, 2'b00});
        nib_eq = (nib_a == nib_b);
        nib_gt = (nib_a > nib_b);
    end

    // Next-state and result logic; flush overrides every handshake
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        eq_d    = eq_q;
        gt_d    = gt_q;
        lt_d    = lt_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    idx_d   = IW'(N - 1);
                    cnt_d   = '0;
                    eq_d    = 1'b0;
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    state_d = CMP;
                end
            end
            CMP: begin
                cnt_d = cnt_q + CW'(1);
                if (!nib_eq) begin
                    eq_d    = 1'b0;
                    gt_d    = nib_gt;
                    lt_d    = !nib_gt;
                    state_d = DONE;
                end else if (idx_q == '0) begin
                    eq_d    = 1'b1;
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - IW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
            eq_d    = 1'b0;
            gt_d    = 1'b0;
            lt_d    = 1'b0;
        end
    end

    // State, latched operands and registered results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
        end
    end

    // Handshake and status outputs decode directly from the state register
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
        eq        = eq_q;
        gt        = gt_q;
        lt        = lt_q;
        nib_cnt   = cnt_q;
    end

endmodule

// File: tb/tb_seq_cmp32_ctrl.sv
// Directed bench for seq_cmp32_ctrl at WIDTH=32 with hand-computed results.
module tb_seq_cmp32_ctrl;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic        eq;
    logic        gt;
    logic        lt;
    logic [3:0]  nib_cnt;
    logic        busy;

    int checkCount = 0;
    int passCount  = 0;
    int latency;

    seq_cmp32_ctrl #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .eq        (eq),
        .gt        (gt),
        .lt        (lt),
        .nib_cnt   (nib_cnt),
        .busy      (busy)
    );

    // Free-running 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Present an operand pair and let it be accepted; afterwards scramble the
    // inputs so any late sampling of a/b corrupts the result
    task automatic applyStimulus(input logic [31:0] opA, input logic [31:0] opB,
                                 input logic holdValid, input string tag);
        @(negedge clk);
        a        = opA;
        b        = opB;
        in_valid = 1'b1;
        checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = holdValid;
        a        = ~opA ^ 32'h5A5A_3C3C;
        b        = opA ^ 32'h0F0F_0F0F;
    endtask

    // Count edges from the accept edge until out_valid rises, bounded
    task automatic waitResult(input string tag, output int k);
        k = 0;
        while (!out_valid && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (!out_valid) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic checkResult(input string tag, input int k, input int expCnt,
                               input logic expEq, input logic expGt, input logic expLt);
        checkOutput({tag, "_latency"}, 32'(k), 32'(expCnt));
        checkOutput({tag, "_eq"}, 32'(eq), 32'(expEq));
        checkOutput({tag, "_gt"}, 32'(gt), 32'(expGt));
        checkOutput({tag, "_lt"}, 32'(lt), 32'(expLt));
        checkOutput({tag, "_nib_cnt"}, 32'(nib_cnt), 32'(expCnt));
    endtask

    task automatic runCompare(input logic [31:0] opA, input logic [31:0] opB, input string tag,
                              input int expCnt, input logic expEq, input logic expGt, input logic expLt);
        applyStimulus(opA, opB, 1'b0, tag);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
        waitResult(tag, latency);
        checkResult(tag, latency, expCnt, expEq, expGt, expLt);
        @(posedge clk);
        #1;
        checkOutput({tag, "_drained"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_idle"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;

        #12;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_flags", {29'd0, eq, gt, lt}, 32'd0);
        checkOutput("rst_nib_cnt", 32'(nib_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Equal operands walk all eight nibbles
        runCompare(32'hDEAD_BEEF, 32'hDEAD_BEEF, "equal", 8, 1'b1, 1'b0, 1'b0);
        // MSB nibble 8 vs 7 exits on the first compare
        runCompare(32'h8000_0000, 32'h7FFF_FFFF, "msb_exit", 1, 1'b0, 1'b1, 1'b0);
        // Only the LSB nibble differs
        runCompare(32'h1234_5670, 32'h1234_5671, "lsb_diff", 8, 1'b0, 1'b0, 1'b1);
        // Fourth nibble F vs E
        runCompare(32'hFFFF_0000, 32'hFFFE_0000, "mid_gt", 4, 1'b0, 1'b1, 1'b0);
        runCompare(32'h0000_0000, 32'h0000_0000, "zeros", 8, 1'b1, 1'b0, 1'b0);

        // Backpressure with in_valid held high the whole time
        out_ready = 1'b0;
        applyStimulus(32'h00F0_0000, 32'h00E0_0000, 1'b1, "bp");
        a = 32'h00F0_0000;
        b = 32'h00E0_0000;
        waitResult("bp", latency);
        checkResult("bp", latency, 3, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checkOutput("bp_hold_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_hold_gt", 32'(gt), 32'd1);
            checkOutput("bp_hold_cnt", 32'(nib_cnt), 32'd3);
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp_released", 32'(out_valid), 32'd0);
        checkOutput("bp_no_same_edge_accept", 32'(busy), 32'd0);
        checkOutput("bp_in_ready_back", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("bp_stays_idle", 32'(busy), 32'd0);

        // Reset on the fourth CMP cycle of an equal compare
        applyStimulus(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, "rst_mid");
        repeat (3) @(posedge clk);
        #2;
        checkOutput("rst_mid_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_busy", 32'(busy), 32'd0);
        checkOutput("rst_mid_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_mid_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_mid_nib_cnt", 32'(nib_cnt), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        runCompare(32'd5, 32'd9, "post_rst", 8, 1'b0, 1'b0, 1'b1);

        // Flush colliding with an input handshake
        @(negedge clk);
        a        = 32'h1111_1111;
        b        = 32'h2222_2222;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("flush_in_busy", 32'(busy), 32'd0);
        checkOutput("flush_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        flush    = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("flush_in_still_idle", 32'(busy), 32'd0);
        checkOutput("flush_in_no_result", 32'(out_valid), 32'd0);

        // Flush colliding with an output handshake in DONE
        out_ready = 1'b0;
        applyStimulus(32'h0000_0001, 32'h1000_0000, 1'b0, "flush_out");
        waitResult("flush_out", latency);
        checkResult("flush_out", latency, 1, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        flush     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
        checkOutput("flush_out_busy", 32'(busy), 32'd0);
        checkOutput("flush_out_in_ready", 32'(in_ready), 32'd1);
        flush = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("flush_out_no_result", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/seq_cmp32_ctrl.md
SEQ_CMP32_CTRL -- requirements
Module: seq_cmp32_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the operand width in bits; it SHALL be a multiple of 4 and at least 4.
REQ-002 The block SHALL define the derived constant N = WIDTH/4, the number of nibbles, and CW = clog2(N)+1, the width of the nibble-count output.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on the rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port flush, input, 1 bit: synchronous abort.
REQ-006 Port in_valid, input, 1 bit: the operand pair is valid.
REQ-007 Port in_ready, output, 1 bit: the block can accept an operand pair.
REQ-008 Port a, input, WIDTH bits: operand A, unsigned.
REQ-009 Port b, input, WIDTH bits: operand B, unsigned.
REQ-010 Port out_valid, output, 1 bit: the result is valid.
REQ-011 Port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 Ports eq, gt and lt, outputs, 1 bit each: A==B, A>B and A<B respectively.
REQ-013 Port nib_cnt, output, CW bits: the number of nibble compares used to produce the result.
REQ-014 Port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-015 The block SHALL use a single 4-bit nibble comparator (equal and greater) that is time-shared across the nibbles; a full-width compare SHALL NOT be used.
REQ-016 The state machine SHALL have exactly three states: IDLE, CMP and DONE.
REQ-017 in_ready SHALL be 1 only in IDLE.
REQ-018 When in_valid and in_ready are both 1 at a clock edge, the block SHALL latch a and b, set the nibble index to N-1 (the MSB nibble), and go to CMP.
REQ-019 In CMP, on each cycle the block SHALL compare nibble[idx] of the latched A against nibble[idx] of the latched B.
  - Nibbles differ: the block SHALL register gt and lt from that compare, set eq=0, and go to DONE (early exit).
  - Nibbles equal and idx==0: the block SHALL register eq=1, gt=0, lt=0, and go to DONE.
  - Otherwise: idx SHALL decrement and the state SHALL stay in CMP.
REQ-020 nib_cnt SHALL equal the number of CMP cycles spent, in the range 1..N.
REQ-021 Latency: out_valid SHALL rise k edges after the accept edge, where k = nib_cnt.
  - Operands equal: k = N.
  - First differing nibble at position j from the MSB (j = 0..N-1): k = j+1.
REQ-022 out_valid SHALL be 1 only in DONE.
REQ-023 While in DONE with out_ready=0, eq, gt, lt and nib_cnt SHALL hold stable.
REQ-024 When out_valid and out_ready are both 1 at an edge, the block SHALL go to IDLE; no new operand pair is accepted on that same edge.
REQ-025 Exactly one of eq, gt and lt SHALL be 1 whenever out_valid=1.
REQ-026 Changes on a and b after the accept edge SHALL NOT affect the result.
REQ-027 A flush=1 at an edge, in any state, SHALL force IDLE, clear out_valid, and discard the operation in flight.
  - flush SHALL take priority over an input handshake on the same edge.
  - flush SHALL take priority over an output handshake on the same edge.
REQ-028 in_valid asserted outside IDLE SHALL be ignored and SHALL NOT be queued.

Reset
REQ-029 While rst_n=0, the block SHALL immediately (asynchronously) force the state to IDLE.
REQ-030 While rst_n=0, the outputs SHALL be: out_valid=0, eq=0, gt=0, lt=0, nib_cnt=0, busy=0, in_ready=1.
REQ-031 Reset asserted mid-CMP or in DONE SHALL abandon the operation.
REQ-032 After reset is deasserted, the first accepted operand pair SHALL behave exactly as it would from power-up.

Verification (WIDTH=32, N=8)
REQ-033 The bench SHALL cover the equal case:
  - Stimulus: a=b=0xDEADBEEF, out_ready=1.
  - Required: out_valid rises 8 edges after accept; eq=1, gt=0, lt=0, nib_cnt=8.
REQ-034 The bench SHALL cover early exit at the MSB:
  - Stimulus: a=0x80000000, b=0x7FFFFFFF.
  - Required: out_valid rises 1 edge after accept; gt=1, nib_cnt=1.
REQ-035 The bench SHALL cover a difference in the LSB nibble:
  - Stimulus: a=0x12345670, b=0x12345671.
  - Required: lt=1, nib_cnt=8.
REQ-036 The bench SHALL cover backpressure:
  - Stimulus: a=0x00F00000, b=0x00E00000, out_ready=0 for 5 cycles after out_valid rises, with in_valid held at 1 throughout.
  - Required: gt=1 and nib_cnt=3 held stable; in_ready=0 until 1 cycle after the output handshake.
REQ-037 The bench SHALL cover reset mid-operation:
  - Stimulus: rst_n pulled low for 1 cycle on the 4th CMP cycle of an equal compare.
  - Required: busy=0 and out_valid=0 immediately; a subsequent compare a=5, b=9 yields lt=1, nib_cnt=8.
REQ-038 The bench SHALL cover flush collisions:
  - Stimulus: flush=1 on the same edge as an input handshake, then flush=1 in DONE while out_ready=1.
  - Required: state is IDLE after each flush, with no result delivered.
